// File: rtl/display_timing_480p_if.sv
// display_timing_480p_if
//   Bundles the timing outputs of display_timing_480p for paint/VGA stages.
//   master : driven by the timing generator
//   slave  : consumed by downstream logic
//   sx, sy        screen coordinates (CORDW bits)
//   hsync, vsync  sync pulses, polarity set by the generator
//   de            data enable, active picture only
//   line, frame   one-cycle strobes at start of line / frame
interface display_timing_480p_if #(
    parameter int CORDW = 10
);
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             line;
    logic             frame;

    modport master (output sx, sy, hsync, vsync, de, line, frame);
    modport slave  (input  sx, sy, hsync, vsync, de, line, frame);
endinterface

// File: rtl/display_timing_480p.sv
// display_timing_480p
//   Display timing generator (640x480 @ 60 Hz by default, 800x525 total).
//   Ports:
//     clk_pix   pixel clock
//     rst_pix   asynchronous active-high reset
//     o_timing  master modport: sx, sy, hsync, vsync, de, line, frame
//   All outputs are registered together so controls match the coordinates
//   shown in the same cycle.
module display_timing_480p #(
    parameter int CORDW  = 10,
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int H_POL  = 0,
    parameter int V_POL  = 0
) (
    input  logic                  clk_pix,
    input  logic                  rst_pix,
    display_timing_480p_if.master o_timing
);
    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC - 1);

    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    logic [CORDW-1:0] r_sx;
    logic [CORDW-1:0] r_sy;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic             r_line;
    logic             r_frame;

    logic [CORDW-1:0] w_sx_next;
    logic [CORDW-1:0] w_sy_next;
    logic             w_hs_act;
    logic             w_vs_act;

    // Controls are decoded from the next coordinates so that, once
    // registered, they line up with the registered coordinates.
    always_comb begin
        w_sx_next = r_sx + CORDW'(1);
        w_sy_next = r_sy;
        if (r_sx == H_LAST) begin
            w_sx_next = '0;
            if (r_sy == V_LAST) begin
                w_sy_next = '0;
            end else begin
                w_sy_next = r_sy + CORDW'(1);
            end
        end
        w_hs_act = (w_sx_next >= HS_BEG) && (w_sx_next <= HS_END);
        w_vs_act = (w_sy_next >= VS_BEG) && (w_sy_next <= VS_END);
    end

    // Reset parks the counters on the last pixel so the first edge after
    // release lands on (0,0) with line and frame strobes.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_sx    <= H_LAST;
            r_sy    <= V_LAST;
            r_hsync <= ~HS_ON;
            r_vsync <= ~VS_ON;
            r_de    <= 1'b0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_sx    <= w_sx_next;
            r_sy    <= w_sy_next;
            r_hsync <= w_hs_act ? HS_ON : ~HS_ON;
            r_vsync <= w_vs_act ? VS_ON : ~VS_ON;
            r_de    <= (w_sx_next < H_ACT) && (w_sy_next < V_ACT);
            r_line  <= (w_sx_next == '0);
            r_frame <= (w_sx_next == '0) && (w_sy_next == '0);
        end
    end

    assign o_timing.sx    = r_sx;
    assign o_timing.sy    = r_sy;
    assign o_timing.hsync = r_hsync;
    assign o_timing.vsync = r_vsync;
    assign o_timing.de    = r_de;
    assign o_timing.line  = r_line;
    assign o_timing.frame = r_frame;
endmodule

// File: doc/display_timing_480p.md
# display_timing_480p

Pixel-clock display timing generator for 640x480 at 60 Hz (800x525 total, 25.2 MHz nominal pixel clock). It sits between the pixel clock generator and the drawing/paint logic. It produces the screen coordinates, sync pulses and data-enable that downstream paint and VGA output stages consume, plus line and frame strobes for per-line and per-frame logic such as animation.

## Interface
- CORDW, 10: width of the sx/sy coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1.
- H_RES, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_RES, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- H_POL, 0: hsync active level; 0 = active-low, 1 = active-high.
- V_POL, 0: vsync active level; 0 = active-low, 1 = active-high.
- clk_pix  input  1  pixel clock; the block's only clock.
- rst_pix  input  1  reset, asynchronous, active-high; normally driven by the inverted clock-lock signal.
- sx  output  CORDW  horizontal position, 0..H_TOTAL-1.
- sy  output  CORDW  vertical position, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync, level set by H_POL.
- vsync  output  1  vertical sync, level set by V_POL.
- de  output  1  data enable; high only in the active picture area.
- line  output  1  one-cycle strobe at the start of every line (sx==0), blanking lines included.
- frame  output  1  one-cycle strobe at the start of every frame (sx==0 and sy==0).

## Operation
- Derived constants:
  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (525 by default).
- Horizontal counter:
  - sx increments by 1 every clk_pix cycle.
  - At H_TOTAL-1 it wraps to 0, and sy advances.
- Vertical counter:
  - sy increments on each horizontal wrap.
  - When sx==H_TOTAL-1 and sy==V_TOTAL-1, both counters wrap to 0 together.
- Sync windows:
  - hsync is active for sx in [H_RES+H_FP, H_RES+H_FP+H_SYNC-1], which is 656..751 by default; inactive otherwise.
  - vsync is active for sy in [V_RES+V_FP, V_RES+V_FP+V_SYNC-1], which is 490..491 by default. It is asserted for whole lines, sx 0..799.
- de = (sx < H_RES) && (sy < V_RES).
- Inactive sync level is the complement of the active level: H_POL=0 gives hsync idle high.
- Counter arithmetic is unsigned at CORDW bits. Comparisons must never rely on overflow wrap; the wrap is explicit at H_TOTAL-1 and V_TOTAL-1.
- No state machine beyond the two counters. Every output is a pure function of the current (sx, sy) pair, held in registers.

## Timing
- Everything is registered on posedge clk_pix. hsync, vsync, de, line and frame in any cycle correspond exactly to the sx/sy shown in that same cycle; there is zero skew between coordinates and controls.
- Reset values, applied asynchronously and immediately on rst_pix assertion with no clock edge needed:
  - sx = H_TOTAL-1 (799)
  - sy = V_TOTAL-1 (524)
  - hsync = inactive, vsync = inactive
  - de = 0, line = 0, frame = 0
- First rising edge after rst_pix deasserts: sx=0, sy=0, de=1, line=1, frame=1.
- Reset asserted mid-frame: outputs snap to the reset values asynchronously. No partial sync pulse may continue; hsync and vsync go inactive in the same instant.
- Periods:
  - line: every H_TOTAL cycles.
  - frame: every H_TOTAL*V_TOTAL cycles (420000 by default).
  - de high for H_RES*V_RES cycles per frame (307200 by default).
- frame and line coincide at (0,0). line stays asserted during vsync and blanking lines.

## Test plan
- Reset release: hold rst_pix for 5 cycles, then release. The first edge gives sx=0, sy=0, de=1, line=1, frame=1. The next edge gives sx=1, line=0, frame=0.
- Horizontal timing: on sy=0, hsync is low for exactly sx=656..751 (96 cycles), de is high for sx=0..639, and sx=799 is followed by sx=0 with sy=1.
- Vertical timing: over one full frame, vsync is low only for sy=490..491 (1600 cycles), de is high for 307200 cycles total, and (799,524) is followed by (0,0) with frame=1.
- Strobe periods: frame pulses are exactly 420000 cycles apart, and line pulses are exactly 800 cycles apart, 525 per frame.
- Async reset mid-frame: assert rst_pix between clock edges at sx=700, sy=491, while hsync and vsync are both active. Before the next edge, outputs are sx=799, sy=524, hsync=1, vsync=1, de=0.
- Polarity: with H_POL=1 and V_POL=1, hsync is high only for sx=656..751 and vsync is high only for sy=490..491. The inactive level is 0, including at reset.
